liteeth_sram_fifo_ctrl: RTL and testbench

- Synchronous stream FIFO controller built around an external fakeram_1rw1r 12w128d macro.
- Writes go through the rw0 port (write-only use). Reads go through the r0 port, which has 1-cycle read latency.
- A 2-entry output buffer gives full-throughput valid/ready streaming with backpressure.
- Sits between LiteEth MAC/packet stages that need deep, cheap buffering instead of flop FIFOs.

---
 rtl/liteeth_sram_fifo_ctrl_pkg.sv | 16 +
 rtl/liteeth_sram_fifo_ctrl_if.sv | 26 ++
 rtl/liteeth_sram_fifo_obuf.sv | 57 +++++
 rtl/liteeth_sram_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/liteeth_sram_fifo_ctrl_pkg.sv
// rtl/liteeth_sram_fifo_ctrl_pkg.sv - shared constants and types for the SRAM-backed stream FIFO
// Purpose: geometry of the fakeram_1rw1r 12w128d macro and the word/address/level types.
// Ports: none (package).
package liteeth_sram_pkg;

  localparam int BITS       = 12;
  localparam int ADDR_WIDTH = 7;
  // Depth is tied to the address width; the macro has no unused rows.
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [BITS-1:0]       word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  // One extra bit: the level counts the macro plus the in-flight word and output buffer.
  typedef logic [ADDR_WIDTH:0]   level_t;

endpackage

// File: rtl/liteeth_sram_fifo_ctrl_if.sv
// rtl/liteeth_sram_fifo_ctrl_if.sv - sink/source stream handshake bundle
// Purpose: groups the write-side (sink) and read-side (source) valid/ready/data signals.
// Ports: sink_valid/sink_ready/sink_data, source_valid/source_ready/source_data.
//   slave  - the FIFO side (accepts sink, drives source)
//   master - the producer/consumer side
interface liteeth_sram_fifo_ctrl_if;
  import liteeth_sram_pkg::*;

  logic  sink_valid;
  logic  sink_ready;
  word_t sink_data;
  logic  source_valid;
  logic  source_ready;
  word_t source_data;

  modport slave (
    input  sink_valid, sink_data, source_ready,
    output sink_ready, source_valid, source_data
  );

  modport master (
    output sink_valid, sink_data, source_ready,
    input  sink_ready, source_valid, source_data
  );

endinterface

// File: rtl/liteeth_sram_fifo_obuf.sv
// rtl/liteeth_sram_fifo_obuf.sv - 2-entry in-order output buffer behind the macro read port
// Purpose: holds words returned by the macro so the source side can stream at full rate.
// Ports: clk/rst (async active-high), push/data_in (capture), pop (consume head),
//   flush (sync clear), count (0..2), head (oldest entry).
module liteeth_sram_fifo_obuf
  import liteeth_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  word_t      data_in,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output word_t      head
);

  word_t e0;
  word_t e1;

  assign head = e0;

  // The controller never pushes into a full buffer without a pop and never pops
  // an empty one, so those cases need no handling here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= data_in;
          else               e1 <= data_in;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count unchanged: the new word lands just behind the surviving entry.
          if (count == 2'd1) begin
            e0 <= data_in;
          end else begin
            e0 <= e1;
            e1 <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// rtl/liteeth_sram_fifo_ctrl.sv - stream FIFO controller around a fakeram_1rw1r 12w128d macro
// Purpose: writes via rw0 (write-only), reads via r0 (1-cycle latency), with a 2-entry
//   output buffer giving 1 word/cycle throughput under backpressure.
// Ports: sys_clk, sys_rst (async active-high), flush (sync clear), strm (sink/source
//   stream), level (mem + in-flight + output buffer), rw0_* and r0_* macro ports.
module liteeth_sram_fifo_ctrl
  import liteeth_sram_pkg::*;
(
  input  logic   sys_clk,
  input  logic   sys_rst,
  input  logic   flush,
  liteeth_sram_fifo_ctrl_if.slave strm,
  output level_t level,
  output logic   rw0_clk,
  output logic   rw0_ce_in,
  output logic   rw0_we_in,
  output addr_t  rw0_addr_in,
  output word_t  rw0_wd_in,
  input  word_t  rw0_rd_out,
  output logic   r0_clk,
  output logic   r0_ce_in,
  output addr_t  r0_addr_in,
  input  word_t  r0_rd_out
);

  addr_t      wr_ptr;
  addr_t      rd_ptr;
  level_t     mem_count;
  logic       inflight;
  logic [1:0] ob_count;
  word_t      ob_head;

  logic sink_ready;
  logic push;
  logic pop;
  logic issue;
  logic unused_rw0_rd;

  // The rw0 port is used write-only; its read data is intentionally ignored.
  assign unused_rw0_rd = ^rw0_rd_out;

  assign rw0_clk = sys_clk;
  assign r0_clk  = sys_clk;

  // sys_rst is in the term so the strobes drop the instant reset asserts.
  assign sink_ready = !sys_rst && !flush && (mem_count < level_t'(DEPTH));
  assign push       = strm.sink_valid && sink_ready;
  assign pop        = strm.source_valid && strm.source_ready && !flush;

  // Issue only if the buffer will have room when the word returns:
  // ob_count + inflight - pop < 2, rearranged to stay unsigned.
  assign issue = !sys_rst && !flush && (mem_count != '0) &&
                 (({1'b0, ob_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign strm.sink_ready   = sink_ready;
  assign strm.source_valid = (ob_count != 2'd0);
  assign strm.source_data  = ob_head;

  assign rw0_ce_in   = push;
  assign rw0_we_in   = push;
  assign rw0_addr_in = wr_ptr;
  assign rw0_wd_in   = strm.sink_data;

  assign r0_ce_in   = issue;
  assign r0_addr_in = rd_ptr;

  assign level = mem_count + level_t'(inflight) + level_t'(ob_count);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + addr_t'(1);
      if (issue) rd_ptr <= rd_ptr + addr_t'(1);
      mem_count <= mem_count + level_t'(push) - level_t'(issue);
      inflight  <= issue;
    end
  end

  // A word read last cycle is on r0_rd_out now; flush inside the buffer drops it.
  liteeth_sram_fifo_obuf u_obuf (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (inflight),
    .data_in (r0_rd_out),
    .pop     (pop),
    .flush   (flush),
    .count   (ob_count),
    .head    (ob_head)
  );

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb/tb_liteeth_sram_fifo_ctrl.sv - self-checking bench for liteeth_sram_fifo_ctrl
module tb_liteeth_sram_fifo_ctrl;
  import liteeth_sram_pkg::*;

  logic   sys_clk = 1'b0;
  logic   sys_rst;
  logic   flush;
  level_t level;
  logic   rw0_clk, rw0_ce_in, rw0_we_in;
  addr_t  rw0_addr_in;
  word_t  rw0_wd_in;
  word_t  rw0_rd_out;
  logic   r0_clk, r0_ce_in;
  addr_t  r0_addr_in;
  word_t  r0_rd_out;

  liteeth_sram_fifo_ctrl_if bus ();

  liteeth_sram_fifo_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flush       (flush),
    .strm        (bus),
    .level       (level),
    .rw0_clk     (rw0_clk),
    .rw0_ce_in   (rw0_ce_in),
    .rw0_we_in   (rw0_we_in),
    .rw0_addr_in (rw0_addr_in),
    .rw0_wd_in   (rw0_wd_in),
    .rw0_rd_out  (rw0_rd_out),
    .r0_clk      (r0_clk),
    .r0_ce_in    (r0_ce_in),
    .r0_addr_in  (r0_addr_in),
    .r0_rd_out   (r0_rd_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural 12w128d macro: rw0 write port, r0 read port with 1-cycle latency.
  word_t ram [DEPTH];
  assign rw0_rd_out = '0;
  always @(posedge sys_clk) begin
    if (rw0_ce_in && rw0_we_in) ram[rw0_addr_in] <= rw0_wd_in;
    if (r0_ce_in) r0_rd_out <= ram[r0_addr_in];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Both strobes high in one cycle must never target the same address.
  always @(negedge sys_clk) begin
    #2;
    if (rw0_ce_in && r0_ce_in)
      check("addr_collision", int'(rw0_addr_in != r0_addr_in), 1);
  end

  // Drive inputs at the falling edge and leave outputs settled for sampling.
  task automatic step(input logic sv, input word_t d, input logic sr, input logic fl);
    @(negedge sys_clk);
    bus.sink_valid   = sv;
    bus.sink_data    = d;
    bus.source_ready = sr;
    flush            = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    bus.sink_valid = 1'b0; bus.sink_data = '0; bus.source_ready = 1'b0; flush = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  typedef struct {
    logic  sv;
    word_t d;
    logic  sr;
    logic  fl;
    logic  e_srdy;
    logic  e_wce;
    logic  e_rce;
    logic  e_valid;
    word_t e_data;
    int    e_level;
  } vec_t;

  vec_t vt [10];

  initial begin
    int accepted, exp_w, pushed, got, errs, gaps, maxlvl, first_push, first_valid;
    logic sr;
    word_t q [$];
    word_t w;

    vt[0] = '{1'b1, 12'h111, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 0};
    vt[1] = '{1'b1, 12'h222, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1};
    vt[2] = '{1'b0, 12'h000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2};
    vt[3] = '{1'b0, 12'h000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 12'h111, 2};
    vt[4] = '{1'b0, 12'h000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 12'h111, 2};
    vt[5] = '{1'b0, 12'h000, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 12'h111, 2};
    vt[6] = '{1'b0, 12'h000, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 12'h222, 1};
    vt[7] = '{1'b0, 12'h000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 0};
    vt[8] = '{1'b1, 12'h333, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 0};
    vt[9] = '{1'b0, 12'h000, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 0};

    // Reset held from time zero, with a write request pending.
    sys_rst = 1'b1; flush = 1'b0;
    bus.sink_valid = 1'b1; bus.sink_data = 12'hABC; bus.source_ready = 1'b1;
    #3;
    check("rst_source_valid", int'(bus.source_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_sink_ready", int'(bus.sink_ready), 0);
    check("rst_rw0_ce", int'(rw0_ce_in), 0);
    check("rst_r0_ce", int'(r0_ce_in), 0);
    do_reset();

    // Table-driven single-cycle vectors from an empty FIFO.
    for (int i = 0; i < 10; i++) begin
      step(vt[i].sv, vt[i].d, vt[i].sr, vt[i].fl);
      check($sformatf("vec%0d_sink_ready", i), int'(bus.sink_ready), int'(vt[i].e_srdy));
      check($sformatf("vec%0d_rw0_ce", i), int'(rw0_ce_in), int'(vt[i].e_wce));
      check($sformatf("vec%0d_r0_ce", i), int'(r0_ce_in), int'(vt[i].e_rce));
      check($sformatf("vec%0d_source_valid", i), int'(bus.source_valid), int'(vt[i].e_valid));
      check($sformatf("vec%0d_level", i), int'(level), vt[i].e_level);
      if (vt[i].e_valid)
        check($sformatf("vec%0d_source_data", i), int'(bus.source_data), int'(vt[i].e_data));
    end

    // Asynchronous reset in the middle of a cycle with both strobes active.
    do_reset();
    step(1'b1, 12'h011, 1'b0, 1'b0);
    step(1'b1, 12'h012, 1'b0, 1'b0);
    check("midrst_pre_r0_ce", int'(r0_ce_in), 1);
    #1 sys_rst = 1'b1;
    #1;
    check("midrst_r0_ce", int'(r0_ce_in), 0);
    check("midrst_rw0_ce", int'(rw0_ce_in), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_source_valid", int'(bus.source_valid), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0; bus.sink_valid = 1'b0;
    #1;
    check("postrst_sink_ready", int'(bus.sink_ready), 1);

    // Fill with no consumer: exactly DEPTH+2 words accepted.
    do_reset();
    accepted = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, word_t'(accepted + 1), 1'b0, 1'b0);
      if (bus.sink_ready) accepted++;
    end
    check("fill_accepted", accepted, 130);
    check("fill_level", int'(level), 130);
    check("fill_sink_ready", int'(bus.sink_ready), 0);
    exp_w = 1;
    for (int c = 0; c < 400 && exp_w <= 130; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (bus.source_valid) begin
        check($sformatf("drain_word%0d", exp_w), int'(bus.source_data), exp_w);
        exp_w++;
      end
    end
    check("drain_count", exp_w - 1, 130);
    step(1'b0, '0, 1'b0, 1'b0);
    check("drain_level", int'(level), 0);

    // Full-rate streaming: 3-cycle latency, no gaps, level bounded.
    do_reset();
    pushed = 0; got = 0; errs = 0; gaps = 0; maxlvl = 0; first_push = -1; first_valid = -1;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      step(pushed < 1000, word_t'(pushed + 1), 1'b1, 1'b0);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (bus.sink_valid && bus.sink_ready) begin
        if (first_push < 0) first_push = c;
        pushed++;
      end
      if (bus.source_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bus.source_data != word_t'(got + 1)) errs++;
        got++;
      end else if (first_valid >= 0) begin
        gaps++;
      end
    end
    check("stream_latency", first_valid - first_push, 3);
    check("stream_count", got, 1000);
    check("stream_data_errs", errs, 0);
    check("stream_gaps", gaps, 0);
    check("stream_level_over3", int'(maxlvl > 3), 0);

    // Random backpressure across several pointer wraps, scoreboard-checked.
    do_reset();
    pushed = 0; got = 0; errs = 0;
    q.delete();
    for (int c = 0; c < 6000 && got < 600; c++) begin
      sr = 1'($urandom_range(0, 1));
      step(pushed < 600, word_t'(pushed * 7 + 3), sr, 1'b0);
      if (bus.sink_valid && bus.sink_ready) begin
        q.push_back(bus.sink_data);
        pushed++;
      end
      if (bus.source_valid && bus.source_ready) begin
        if (q.size() == 0) begin
          errs++;
        end else begin
          w = q.pop_front();
          if (bus.source_data != w) errs++;
        end
        got++;
      end
    end
    check("wrap_count", got, 600);
    check("wrap_data_errs", errs, 0);
    check("wrap_leftover", q.size(), 0);

    // Flush while a read is in flight and the buffer holds a word.
    do_reset();
    step(1'b1, 12'h0A1, 1'b0, 1'b0);
    step(1'b1, 12'h0A2, 1'b0, 1'b0);
    step(1'b1, 12'h0A3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("flush_pre_level", int'(level), 3);
    check("flush_pre_head", int'(bus.source_data), 12'h0A1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_pre_r0_ce", int'(r0_ce_in), 1);
    step(1'b1, 12'h777, 1'b1, 1'b1);
    check("flush_sink_ready", int'(bus.sink_ready), 0);
    check("flush_rw0_ce", int'(rw0_ce_in), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("flush_source_valid", int'(bus.source_valid), 0);
    check("flush_level", int'(level), 0);
    step(1'b1, 12'h5A5, 1'b0, 1'b0);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (bus.source_valid) begin
        check("flush_next_data", int'(bus.source_data), 12'h5A5);
        got = 1;
      end
    end
    check("flush_next_seen", got, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_stale", int'(bus.source_valid), 0);
    check("flush_end_level", int'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
